// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter: round-robin sharing of one start/done multiplier among N_REQ requesters
module mul_share_arbiter #(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [WIDTH*N_REQ-1:0] req_in1,
    input  logic [WIDTH*N_REQ-1:0] req_in2,
    output logic [N_REQ-1:0]       req_ready,
    output logic [N_REQ-1:0]       resp_valid,
    output logic [2*WIDTH-1:0]     resp_data,
    output logic                   resp_err,
    output logic                   mul_start,
    output logic [WIDTH-1:0]       mul_in1,
    output logic [WIDTH-1:0]       mul_in2,
    input  logic [2*WIDTH-1:0]     mul_result,
    input  logic                   mul_done,
    output logic                   busy
);
    localparam int GW = $clog2(N_REQ);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t             state_q, state_d;
    logic [GW-1:0]      ptr_q, ptr_d, g_q, g_d, win;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               found;
    logic               mul_start_q, mul_start_d;
    logic [WIDTH-1:0]   mul_in1_q, mul_in1_d, mul_in2_q, mul_in2_d;
    logic [N_REQ-1:0]   resp_valid_q, resp_valid_d;
    logic [2*WIDTH-1:0] resp_data_q, resp_data_d;
    logic               resp_err_q, resp_err_d;
    logic               busy_q;

    // Round-robin scan from ptr; the first requester found wins and is offered ready only in IDLE
    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && req_valid[(int'(ptr_q) + k) % N_REQ]) begin
                win   = GW'((int'(ptr_q) + k) % N_REQ);
                found = 1'b1;
            end
        end
        req_ready = (state_q == IDLE && found) ? N_REQ'(1) << win : '0;
    end

    // Sequencer next state: accept, pulse start, wait for done or watchdog, respond for one cycle
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        g_d          = g_q;
        cnt_d        = cnt_q;
        mul_start_d  = 1'b0;
        mul_in1_d    = mul_in1_q;
        mul_in2_d    = mul_in2_q;
        resp_valid_d = '0;
        resp_data_d  = resp_data_q;
        resp_err_d   = 1'b0;
        case (state_q)
            IDLE: if (found) begin
                state_d     = ISSUE;
                g_d         = win;
                mul_in1_d   = req_in1[int'(win)*WIDTH +: WIDTH];
                mul_in2_d   = req_in2[int'(win)*WIDTH +: WIDTH];
                mul_start_d = 1'b1;
            end
            ISSUE: begin
                state_d = WAIT;
                cnt_d   = '0;
            end
            WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (mul_done) begin
                    state_d      = RESP;
                    resp_data_d  = mul_result;
                    resp_valid_d = N_REQ'(1) << g_q;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d      = RESP;
                    resp_data_d  = '0;
                    resp_err_d   = 1'b1;
                    resp_valid_d = N_REQ'(1) << g_q;
                end
            end
            RESP: begin
                state_d = IDLE;
                ptr_d   = (g_q == GW'(N_REQ - 1)) ? '0 : g_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; reset drops any in-flight transaction
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            g_q          <= '0;
            cnt_q        <= '0;
            mul_start_q  <= 1'b0;
            mul_in1_q    <= '0;
            mul_in2_q    <= '0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            g_q          <= g_d;
            cnt_q        <= cnt_d;
            mul_start_q  <= mul_start_d;
            mul_in1_q    <= mul_in1_d;
            mul_in2_q    <= mul_in2_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_err_q   <= resp_err_d;
            busy_q       <= state_d != IDLE;
        end
    end

    assign mul_start  = mul_start_q;
    assign mul_in1    = mul_in1_q;
    assign mul_in2    = mul_in2_q;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_err   = resp_err_q;
    assign busy       = busy_q;
endmodule

// File: doc/mul_share_arbiter.md
Name: mul_share_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one start/done multi-cycle multiplier datapath (16x16 -> 32) among N_REQ requesters.
- Accepts one request at a time and drives the datapath's start/operand inputs.
- Waits for done with a watchdog timeout, then returns the product to the originating requester.
- Sits between client blocks and the multiplier top level.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WIDTH, 16, operand width; result width is 2*WIDTH.
- TIMEOUT, 64, max cycles in WAIT before the transaction is aborted with error (>=2).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  N_REQ  per-requester request; held with operands until accepted.
- req_in1  in  WIDTH*N_REQ  flattened operand A; slice i is [i*WIDTH +: WIDTH].
- req_in2  in  WIDTH*N_REQ  flattened operand B, same slicing.
- req_ready  out  N_REQ  one-hot accept; a transfer occurs on the edge where req_valid[i] & req_ready[i].
- resp_valid  out  N_REQ  one-hot, single-cycle response strobe to the owning requester.
- resp_data  out  2*WIDTH  product, valid while any resp_valid bit is high.
- resp_err  out  1  high with resp_valid when the transaction timed out.
- mul_start  out  1  single-cycle start pulse to the datapath.
- mul_in1  out  WIDTH  operand A to the datapath; held stable from ISSUE through WAIT.
- mul_in2  out  WIDTH  operand B to the datapath; held stable from ISSUE through WAIT.
- mul_result  in  2*WIDTH  datapath product.
- mul_done  in  1  datapath completion.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- States: IDLE, ISSUE, WAIT, RESP. Reset (synchronous) sets:
  - state=IDLE, priority pointer ptr=0, grant index g=0, watchdog cnt=0;
  - all registered outputs 0: mul_start, mul_in1, mul_in2, resp_valid, resp_data, resp_err, busy.
- req_ready:
  - Combinational; nonzero only in IDLE.
  - Winner = first i with req_valid[i] set, scanning ptr, ptr+1, ... mod N_REQ.
  - req_ready = one-hot(winner). All zero if no req_valid, or if state != IDLE.
- IDLE:
  - On accept edge: latch req_in1/req_in2 slices into mul_in1/mul_in2, set g=winner, go to ISSUE.
  - Requests arriving while busy are not accepted; they wait.
- ISSUE (1 cycle): mul_start=1; cnt cleared; next state WAIT. mul_done is ignored in this cycle.
- WAIT:
  - mul_start=0; cnt increments each cycle.
  - If mul_done=1: register mul_result into resp_data, resp_err=0, go to RESP.
  - Else if cnt == TIMEOUT-1: resp_data=0, resp_err=1, go to RESP.
  - mul_done has priority over timeout in the same cycle.
- RESP (1 cycle):
  - resp_valid = one-hot(g); resp_data and resp_err valid.
  - ptr <= (g+1) mod N_REQ; next state IDLE.
  - resp_valid and resp_err return to 0 the following cycle; resp_data holds its value.
  - No backpressure on responses.
- Latency: accept at edge T; mul_start high in cycle T+1; if datapath done is seen in cycle D, resp_valid is high in cycle D+1. Next accept is possible in the cycle after RESP.
- mul_done outside WAIT (IDLE, ISSUE, RESP) is ignored; a stale done never creates a response.
- Fairness: a requester that has just been served gets lowest priority next round; starvation-free for N_REQ.
- Reset mid-operation (any state): the in-flight transaction is dropped, no resp_valid is issued, ptr returns to 0, and a late mul_done after reset is ignored.
- Operands are unsigned; the block performs no arithmetic on data, only routing and registering.

Test Plan:
- Single request on port 2, in1=16'hA6A9, in2=16'h2446, model latency 5 -> req_ready=4'b0100 for 1 cycle; one mul_start pulse with those operands; resp_valid=4'b0100 for 1 cycle with resp_data=32'h179D5636, resp_err=0.
- After reset, all four ports request at once (port i: in1=i+1, in2=3) -> grants in order 0,1,2,3; responses 3,6,9,12 to the matching ports; ptr wraps to 0; never more than one mul_start per transaction.
- Ports 0 and 1 hold req_valid continuously for 6 transactions -> grants alternate 0,1,0,1,0,1.
- Model never asserts done, TIMEOUT=64 -> resp_valid on the granted port exactly 64 cycles after entering WAIT, with resp_err=1 and resp_data=0; the next pending request is then served normally.
- rst asserted during WAIT, model raises mul_done 2 cycles later -> outputs 0 the cycle after rst, no resp_valid, stale done ignored; a fresh request on port 3 (16'hFFFF x 16'hFFFF) returns 32'hFFFE0001.
- mul_done held high during ISSUE and asserted in the same cycle as cnt hits TIMEOUT-1 -> the done in ISSUE is ignored; the simultaneous done wins with resp_err=0 and the correct product.
